mips_cpu_fetch: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/pc_target_calc.sv | 49 ++++
 rtl/mips_cpu_fetch.sv | 95 +++++++++
 tb/tb_mips_cpu_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU fetch stage.
package mips_cpu_pkg;

    // Fetch-stage sequencing: normal issue, executing a delay slot, stopped.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target selection for the fetch stage.
// Priority: register jump (JR/JALR) > J/JAL > conditional branch.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] instr_readdata,
    input  logic [31:0] rs_data,
    input  logic        jump1,
    input  logic        jump,
    input  logic        pcsrc,
    output logic [31:0] target,
    output logic        redirect
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] r_tgt;
    logic        unused_bits;

    assign pc_plus4 = pc + 32'd4;
    // Word offset, sign-extended and scaled to bytes.
    assign br_off   = {{14{instr_readdata[15]}}, instr_readdata[15:0], 2'b00};
    assign br_tgt   = pc_plus4 + br_off;
    // J-type keeps the 256 MB region of the delay-slot address.
    assign j_tgt    = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
    // Register targets are forced word-aligned.
    assign r_tgt    = {rs_data[31:2], 2'b00};

    // Opcode field and low rs bits play no part in target formation.
    assign unused_bits = ^{instr_readdata[31:26], rs_data[1:0]};

    // Select the highest-priority active control transfer.
    always_comb begin
        target   = 32'd0;
        redirect = 1'b0;
        if (jump1) begin
            target   = r_tgt;
            redirect = 1'b1;
        end else if (jump) begin
            target   = j_tgt;
            redirect = 1'b1;
        end else if (pcsrc) begin
            target   = br_tgt;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch / PC stage: owns the PC, applies control transfers with a
// one-instruction delay slot, and halts when a transfer targets HALT_ADDR.
module mips_cpu_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_enable,
    input  logic [31:0]  instr_readdata,
    input  logic         pcsrc,
    input  logic         jump,
    input  logic         jump1,
    input  logic [31:0]  rs_data,
    output logic [31:0]  instr_address,
    output logic [5:0]   op,
    output logic [5:0]   funct,
    output logic [4:0]   dest,
    output logic [31:0]  pc_link,
    output logic         in_delay_slot,
    output logic         active,
    output fetch_state_t state_dbg
);

    fetch_state_t st_q, st_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  calc_target;
    logic         calc_redirect;

    pc_target_calc u_target (
        .pc             (pc_q),
        .instr_readdata (instr_readdata),
        .rs_data        (rs_data),
        .jump1          (jump1),
        .jump           (jump),
        .pcsrc          (pcsrc),
        .target         (calc_target),
        .redirect       (calc_redirect)
    );

    // Next-state logic; everything holds while clk_enable is low.
    always_comb begin
        st_d     = st_q;
        pc_d     = pc_q;
        target_d = target_q;
        if (clk_enable) begin
            case (st_q)
                RUN: begin
                    pc_d = pc_q + 32'd4;
                    if (calc_redirect) begin
                        target_d = calc_target;
                        st_d     = DELAY;
                    end
                end
                DELAY: begin
                    // Controls from the delay-slot instruction are ignored.
                    pc_d = target_q;
                    st_d = (target_q == HALT_ADDR) ? HALTED : RUN;
                end
                HALTED: begin
                    pc_d = HALT_ADDR;
                end
                default: begin
                    st_d = RUN;
                end
            endcase
        end
    end

    // State, PC and pending-target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= RUN;
            pc_q     <= RESET_VECTOR;
            target_q <= 32'd0;
        end else begin
            st_q     <= st_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    assign instr_address = pc_q;
    assign pc_link       = pc_q + 32'd8;
    assign op            = instr_readdata[31:26];
    assign funct         = instr_readdata[5:0];
    assign dest          = instr_readdata[20:16];
    assign in_delay_slot = (st_q == DELAY);
    assign active        = (st_q != HALTED);
    assign state_dbg     = st_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch with an expected-value queue and monitor.
module tb_mips_cpu_fetch;
  import mips_cpu_pkg::*;

  localparam int W = 66; // {pc[31:0], active, in_delay_slot, instr[31:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         clk_enable = 1'b1;
  logic [31:0]  instr_readdata = 32'd0;
  logic         pcsrc = 1'b0;
  logic         jump = 1'b0;
  logic         jump1 = 1'b0;
  logic [31:0]  rs_data = 32'd0;
  logic [31:0]  instr_address;
  logic [5:0]   op;
  logic [5:0]   funct;
  logic [4:0]   dest;
  logic [31:0]  pc_link;
  logic         in_delay_slot;
  logic         active;
  fetch_state_t state_dbg;

  mips_cpu_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .instr_readdata (instr_readdata),
    .pcsrc          (pcsrc),
    .jump           (jump),
    .jump1          (jump1),
    .rs_data        (rs_data),
    .instr_address  (instr_address),
    .op             (op),
    .funct          (funct),
    .dest           (dest),
    .pc_link        (pc_link),
    .in_delay_slot  (in_delay_slot),
    .active         (active),
    .state_dbg      (state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // driver: one cycle of stimulus plus the outputs expected for that cycle
  task automatic cyc(input logic [31:0] e_pc, input logic e_act, input logic e_ds,
                     input logic [31:0] instr, input logic pcs, input logic j,
                     input logic j1, input logic [31:0] rs, input logic en,
                     input logic rst);
    @(posedge clk);
    #1;
    instr_readdata = instr;
    pcsrc          = pcs;
    jump           = j;
    jump1          = j1;
    rs_data        = rs;
    clk_enable     = en;
    reset          = rst;
    exp_q.push_back({e_pc, e_act, e_ds, instr});
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic e_ds);
    cyc(e_pc, 1'b1, e_ds, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // monitor: compare DUT outputs against the head of the queue mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [31:0]  e_pc;
      logic [31:0]  e_instr;
      logic [1:0]   e_st;
      e       = exp_q.pop_front();
      e_pc    = e[65:34];
      e_instr = e[31:0];
      e_st    = !e[33] ? 2'd2 : (e[32] ? 2'd1 : 2'd0);
      chk("instr_address", instr_address, e_pc);
      chk("pc_link", pc_link, e_pc + 32'd8);
      chk("active", {31'd0, active}, {31'd0, e[33]});
      chk("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e[32]});
      chk("state", {30'd0, state_dbg}, {30'd0, e_st});
      chk("slices", {15'd0, op, funct, dest}, {15'd0, e_instr[31:26], e_instr[5:0], e_instr[20:16]});
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    // reset held across two edges, then sequential fetch
    cyc(32'hBFC0_0000, 1, 0, 32'd0, 0, 0, 0, 32'd0, 1, 1);
    idle(32'hBFC0_0000, 0);
    idle(32'hBFC0_0004, 0);
    idle(32'hBFC0_0008, 0);
    idle(32'hBFC0_000C, 0);
    // taken branch imm=3 at BFC00010 -> BFC00014 slot -> BFC00020
    cyc(32'hBFC0_0010, 1, 0, 32'h1000_0003, 1, 0, 0, 32'd0, 1, 0);
    idle(32'hBFC0_0014, 1);
    // backward branch imm=-2 at BFC00020 -> BFC00024 slot -> BFC0001C
    cyc(32'hBFC0_0020, 1, 0, 32'h1062_FFFE, 1, 0, 0, 32'd0, 1, 0);
    idle(32'hBFC0_0024, 1);
    cyc(32'hBFC0_001C, 1, 0, 32'd0, 0, 0, 0, 32'd0, 1, 1);
    // jump index 0x100 -> B0000400; branch in the slot is ignored
    cyc(32'hBFC0_0000, 1, 0, 32'h0800_0100, 0, 1, 0, 32'd0, 1, 0);
    cyc(32'hBFC0_0004, 1, 1, 32'h1000_0007, 1, 0, 0, 32'd0, 1, 0);
    idle(32'hB000_0400, 0);
    // all three controls: register target 12345674 wins, then 3-cycle stall in slot
    cyc(32'hB000_0404, 1, 0, 32'h0800_0010, 1, 1, 1, 32'h1234_5677, 1, 0);
    cyc(32'hB000_0408, 1, 1, 32'd0, 0, 0, 0, 32'd0, 0, 0);
    cyc(32'hB000_0408, 1, 1, 32'd0, 0, 0, 0, 32'd0, 0, 0);
    cyc(32'hB000_0408, 1, 1, 32'd0, 0, 0, 0, 32'd0, 0, 0);
    idle(32'hB000_0408, 1);
    // stall in RUN holds PC
    cyc(32'h1234_5674, 1, 0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
    idle(32'h1234_5674, 0);
    // reset in the delay slot discards the pending target 0x40
    cyc(32'h1234_5678, 1, 0, 32'd0, 0, 0, 1, 32'h0000_0040, 1, 0);
    cyc(32'h1234_567C, 1, 1, 32'd0, 0, 0, 0, 32'd0, 1, 1);
    idle(32'hBFC0_0000, 0);
    // jump to FFFFFFF8, then sequential wrap through 0 must not halt
    cyc(32'hBFC0_0004, 1, 0, 32'h0000_0008, 0, 0, 1, 32'hFFFF_FFF8, 1, 0);
    idle(32'hBFC0_0008, 1);
    idle(32'hFFFF_FFF8, 0);
    idle(32'hFFFF_FFFC, 0);
    idle(32'h0000_0000, 0);
    cyc(32'h0000_0004, 1, 0, 32'd0, 0, 0, 0, 32'd0, 1, 1);
    // JR to rs=3 (aligned to 0) halts after the slot
    cyc(32'hBFC0_0000, 1, 0, 32'h0060_0008, 0, 0, 1, 32'h0000_0003, 1, 0);
    idle(32'hBFC0_0004, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(32'h0000_0000, 0, 0, $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h0000_0100, 1'($urandom_range(0, 1)), 0);
    end
    // reset recovers from HALTED
    cyc(32'h0000_0000, 0, 0, 32'd0, 0, 0, 0, 32'd0, 1, 1);
    idle(32'hBFC0_0000, 0);
    idle(32'hBFC0_0004, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
